// File: rtl/counter_pkg.sv
// counter_pkg: shared mode constants and next-state result type for the up/down counter.
package counter_pkg;
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;
   // Widest counter supported; instances slice value down to their own WIDTH.
   localparam int CNT_MAX_W = 64;
   typedef struct packed {
      logic [CNT_MAX_W-1:0] value;
      logic                 wrapped;
      logic                 clipped;
   } next_t;
endpackage

// File: rtl/counter_next_calc.sv
// counter_next_calc: combinational next value of a bounded up/down counter with wrap or saturate.
module counter_next_calc
   import counter_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STEP_W = 4
) (
   input  logic [WIDTH-1:0] i_y,
   input  logic [WIDTH-1:0] i_limit,
   input  logic [WIDTH-1:0] i_s,
   input  logic             i_up,
   input  logic             i_sat,
   output next_t            o_res
);
   logic [WIDTH:0] w_y1, w_l1, w_s1, w_m, w_t, w_v;
   logic           w_sat_mode, w_w, w_c;
   // One extra bit keeps limit+1 and y+s exact when limit is all ones.
   assign w_y1       = {1'b0, i_y};
   assign w_l1       = {1'b0, i_limit};
   assign w_s1       = {1'b0, i_s};
   assign w_m        = w_l1 + 1'b1;
   assign w_t        = w_y1 + w_s1;
   assign w_sat_mode = (i_sat == MODE_SAT);
   always_comb begin
      w_v = w_y1;
      w_w = 1'b0;
      w_c = 1'b0;
      if (i_y > i_limit) begin
         w_v = w_sat_mode ? w_l1 : '0;
         w_w = !w_sat_mode;
         w_c = w_sat_mode;
      end else if (i_up) begin
         w_v = (w_t <= w_l1) ? w_t : (w_sat_mode ? w_l1 : w_t - w_m);
         w_w = (w_t > w_l1) && !w_sat_mode;
         w_c = (w_t > w_l1) && w_sat_mode;
      end else begin
         w_v = (w_s1 <= w_y1) ? w_y1 - w_s1 : (w_sat_mode ? '0 : w_y1 + (w_m - w_s1));
         w_w = (w_s1 > w_y1) && !w_sat_mode;
         w_c = (w_s1 > w_y1) && w_sat_mode;
      end
   end
   assign o_res = '{value: CNT_MAX_W'(w_v), wrapped: w_w, clipped: w_c};
endmodule

// File: rtl/updown_counter_param.sv
// updown_counter_param: loadable up/down counter with runtime limit, variable step, wrap/saturate and event flags.
module updown_counter_param
   import counter_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int STEP_W  = 4,
   parameter int RST_VAL = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              clr,
   input  logic              load,
   input  logic [WIDTH-1:0]  loadin,
   input  logic              up,
   input  logic [STEP_W-1:0] step,
   input  logic [WIDTH-1:0]  limit,
   input  logic              sat,
   output logic [WIDTH-1:0]  y,
   output logic              wrap_p,
   output logic              sat_p,
   output logic              ovf,
   output logic              at_zero,
   output logic              at_limit
);
   logic [WIDTH-1:0] r_y, w_step_ext, w_s;
   logic             r_wrap, r_sat, r_ovf;
   next_t            w_res;
   assign w_step_ext = WIDTH'(step);
   assign w_s        = (w_step_ext > limit) ? limit : w_step_ext;
   counter_next_calc #(.WIDTH(WIDTH), .STEP_W(STEP_W)) u_calc (
      .i_y(r_y), .i_limit(limit), .i_s(w_s), .i_up(up), .i_sat(sat), .o_res(w_res)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_y    <= WIDTH'(RST_VAL);
         r_wrap <= 1'b0;
         r_sat  <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (clr) begin
         r_y    <= WIDTH'(RST_VAL);
         r_wrap <= 1'b0;
         r_sat  <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (load) begin
         r_y    <= (loadin > limit) ? limit : loadin;
         r_wrap <= 1'b0;
         r_sat  <= 1'b0;
      end else if (en && step != '0) begin
         r_y    <= WIDTH'(w_res.value);
         r_wrap <= w_res.wrapped;
         r_sat  <= w_res.clipped;
         r_ovf  <= r_ovf | w_res.wrapped | w_res.clipped;
      end else begin
         r_wrap <= 1'b0;
         r_sat  <= 1'b0;
      end
   end
   assign y        = r_y;
   assign wrap_p   = r_wrap;
   assign sat_p    = r_sat;
   assign ovf      = r_ovf;
   assign at_zero  = (r_y == '0);
   assign at_limit = (r_y == limit);
endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
Parametrised up/down loadable counter. It generalises the team's fixed 8-bit up/down/load counter with:
- configurable width and a runtime modulo limit;
- a variable step size;
- selectable wrap or saturate mode;
- gated counting;
- event outputs: wrap pulse, saturation pulse, sticky overflow, zero/limit flags.

It serves as the general-purpose event/timebase counter in the datapath and bench infrastructure.

Parameters:
- WIDTH, 8, counter width in bits (>= 2).
- STEP_W, 4, width of the step input (STEP_W <= WIDTH).
- RST_VAL, 0, value of y after reset and clr (must be <= 2^WIDTH-1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; counting occurs only when en=1.
- clr  input  1  synchronous clear to RST_VAL; also clears ovf.
- load  input  1  synchronous load of loadin.
- loadin  input  WIDTH  load value.
- up  input  1  direction: 1 = up, 0 = down.
- step  input  STEP_W  increment per counting cycle; 0 = hold.
- limit  input  WIDTH  upper bound; counting range is 0..limit inclusive.
- sat  input  1  1 = saturate at bounds, 0 = wrap modulo (limit+1).
- y  output  WIDTH  counter value (registered).
- wrap_p  output  1  registered 1-cycle pulse: the last update wrapped.
- sat_p  output  1  registered 1-cycle pulse: the last update clipped at a bound.
- ovf  output  1  sticky: set by any wrap or clip; cleared by rst/clr.
- at_zero  output  1  combinational, y == 0.
- at_limit  output  1  combinational, y == limit.

Behaviour:
- Reset: rst asserted → immediately y=RST_VAL, wrap_p=0, sat_p=0, ovf=0, with no clock required. Deassertion is synchronised externally. Reset applied mid-count discards the count in progress.
- Priority, evaluated per rising edge: rst > clr > load > (en && step!=0) count > hold.
- clr: y=RST_VAL, ovf=0, wrap_p=0, sat_p=0.
- load: y = min(loadin, limit). wrap_p=0 and sat_p=0; ovf is unchanged.
- Effective step: s = min(step, limit), zero-extended to WIDTH+1 bits. Arithmetic is done in WIDTH+1 bits so that limit=2^WIDTH-1 is handled without overflow.
- Out-of-range y (y > limit, e.g. after limit is lowered): the next counting cycle forces y to limit when sat=1, or to 0 when sat=0, regardless of direction. sat_p or wrap_p pulses accordingly and ovf is set.
- Up count, t = y + s:
  - t <= limit → y=t.
  - else if sat → y=limit, sat_p=1.
  - else → y = t-(limit+1), wrap_p=1.
- Down count:
  - s <= y → y = y-s.
  - else if sat → y=0, sat_p=1.
  - else → y = y+(limit+1)-s, wrap_p=1.
- Holding at a bound in sat mode (e.g. y==limit, up, step>0) counts as a clip: sat_p pulses on every such cycle.
- limit=0: y stays 0. s=0, so no pulses occur; this is an idle hold.
- Pulse timing: wrap_p/sat_p assert in the same cycle the new y is visible, i.e. they are registered alongside y. In every cycle without a wrap/clip they are 0.
- Latency: y updates one clock after the qualifying inputs are sampled.
- en=0: y holds; wrap_p=0, sat_p=0.
- Control inputs (up, sat, limit, step) may change on any cycle and are sampled on every edge.

Decomposition:
- Package counter_pkg holds:
  - the mode constants (MODE_WRAP=0, MODE_SAT=1);
  - a next-state result struct {value, wrapped, clipped}.
- One natural sub-module: counter_next_calc. It is combinational and parametrised by WIDTH/STEP_W. It takes y, limit, s, up and sat, and returns the result struct. The top level holds the registers, priority logic and sticky ovf.

Test Plan:
- WIDTH=8, rst pulsed asynchronously between edges → y=0, flags 0 before the next edge. Load 0x7F, then up with step=1 for 3 cycles → y=0x80, 0x81, 0x82.
- limit=9, sat=0, up, step=3, starting from y=7 → y=0 with wrap_p=1; next cycle y=3 with wrap_p=0; ovf stays 1 until clr.
- limit=9, sat=0, down, step=4, starting from y=2 → y=8 with wrap_p=1. Repeat with sat=1 from y=2 → y=0 with sat_p=1. The following cycle holds y=0 and sat_p pulses again.
- limit=255, sat=0, up, step=1, y=255 → y=0 with wrap_p=1, which checks the WIDTH+1 arithmetic. Separately, load 200 with limit=50 → y=50.
- Same-cycle clr+load+en → y=RST_VAL and ovf=0. load+en with loadin=5 → y=5 and no count applied.
- y=8, limit lowered to 5, up, sat=1 → y=5 with sat_p=1. en=0 for 4 cycles → y holds at 5; at_limit=1, at_zero=0.
